// File: rtl/npc_pkg.sv
// npc_pkg: shared types and constants for the pre-IF next-PC generator.
// Optional return address stack is enabled with NPC_RAS_EN.
package npc_pkg;

    typedef enum logic [2:0] {
        INS_NONE = 3'b000,
        INS_COND = 3'b001,
        INS_JUMP = 3'b010,
        INS_CALL = 3'b011,
        INS_RET  = 3'b100,
        INS_IND  = 3'b101
    } ins_type_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
    localparam int unsigned FETCH_BYTES      = 8;

    // Static prediction: conditionals are taken only when they branch backwards.
    function automatic logic slot_taken(input ins_type_t t, input logic [31:0] tgt,
                                        input logic [31:0] pc);
        logic tk;
        case (t)
            INS_COND: tk = (tgt < pc);
            INS_JUMP, INS_CALL, INS_RET, INS_IND: tk = 1'b1;
            default: tk = 1'b0;
        endcase
        return tk;
    endfunction

endpackage

// File: rtl/npc_gen_if.sv
// npc_gen_if: BTB lookup/hit data, backend redirect and fetch-packet signals of npc_gen.
// master = next-PC generator, slave = surrounding BTB / IF / backend.
interface npc_gen_if;
    import npc_pkg::*;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_ready;
    logic [31:0] fetch_pc_0;
    logic [31:0] fetch_pc_1;
    logic [31:0] target_pc_0;
    logic [31:0] target_pc_1;
    logic [2:0]  ins_type_0;
    logic [2:0]  ins_type_1;
    logic        pc_valid;
    logic [31:0] pc_out;
    logic        slot1_valid;
    logic [1:0]  pred_taken;
    logic [31:0] pred_target;

    modport master (
        input  redirect, redirect_pc, if_ready,
        input  target_pc_0, target_pc_1, ins_type_0, ins_type_1,
        output fetch_pc_0, fetch_pc_1,
        output pc_valid, pc_out, slot1_valid, pred_taken, pred_target
    );

    modport slave (
        output redirect, redirect_pc, if_ready,
        output target_pc_0, target_pc_1, ins_type_0, ins_type_1,
        input  fetch_pc_0, fetch_pc_1,
        input  pc_valid, pc_out, slot1_valid, pred_taken, pred_target
    );

endinterface

// File: rtl/npc_ras.sv
// npc_ras: circular return address stack with saturating occupancy count.
// Only instantiated when NPC_RAS_EN is defined; a full push overwrites the oldest entry.
module npc_ras
    import npc_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [31:0] i_push_data,
    output logic [31:0] o_top,
    output logic        o_empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [31:0]      r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] w_top_idx;

    assign w_top_idx = r_ptr - 1'b1;
    assign o_top     = r_mem[w_top_idx];
    assign o_empty   = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_push) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_cnt != CNT_W'(RAS_DEPTH))
                r_cnt <= r_cnt + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_ptr <= w_top_idx;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_ptr] <= i_push_data;
    end

endmodule

// File: rtl/npc_gen.sv
// npc_gen: fetch PC register, dual-slot BTB lookup and same-cycle next-PC selection.
// Define NPC_RAS_EN to predict returns from an internal return address stack.
module npc_gen
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned RAS_DEPTH = 8
) (
    input logic       clk,
    input logic       reset,
    npc_gen_if.master bus
);

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("npc_gen: RAS_DEPTH must be a power of 2 and at least 2");
    end

    logic [31:0] r_pc_p0;
    logic [31:0] w_pc1;
    logic [31:0] w_seq_pc;
    logic        w_slot1_valid;
    ins_type_t   w_type0;
    ins_type_t   w_type1;
    logic [1:0]  w_taken;
    logic        w_any_taken;
    logic        w_sel_slot1;
    logic [31:0] w_sel_btb;
    logic [31:0] w_eff_target;
    logic [31:0] w_pred_target;

    always_comb begin
        w_pc1         = r_pc_p0 + 32'd4;
        w_seq_pc      = {r_pc_p0[31:3], 3'b000} + 32'(FETCH_BYTES);
        w_slot1_valid = ~r_pc_p0[2];
        w_type0       = ins_type_t'(bus.ins_type_0);
        w_type1       = ins_type_t'(bus.ins_type_1);
        w_taken[0]    = slot_taken(w_type0, bus.target_pc_0, r_pc_p0);
        w_taken[1]    = w_slot1_valid & ~w_taken[0]
                        & slot_taken(w_type1, bus.target_pc_1, w_pc1);
        w_any_taken   = |w_taken;
        w_sel_slot1   = ~w_taken[0];
        w_sel_btb     = w_sel_slot1 ? bus.target_pc_1 : bus.target_pc_0;
    end

`ifdef NPC_RAS_EN
    ins_type_t   w_sel_type;
    logic [31:0] w_sel_pc;
    logic        w_fire;
    logic        w_ras_push;
    logic        w_ras_pop;
    logic [31:0] w_ras_top;
    logic        w_ras_empty;

    always_comb begin
        w_sel_type   = w_sel_slot1 ? w_type1 : w_type0;
        w_sel_pc     = w_sel_slot1 ? w_pc1 : r_pc_p0;
        w_fire       = bus.pc_valid & bus.if_ready;
        w_ras_push   = w_fire & w_any_taken & (w_sel_type == INS_CALL);
        w_ras_pop    = w_fire & w_any_taken & (w_sel_type == INS_RET);
        w_eff_target = (w_sel_type == INS_RET && !w_ras_empty) ? w_ras_top : w_sel_btb;
    end

    npc_ras #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_ras_push),
        .i_pop       (w_ras_pop),
        .i_push_data (w_sel_pc + 32'd4),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty)
    );
`else
    assign w_eff_target = w_sel_btb;
`endif

    assign w_pred_target = w_any_taken ? w_eff_target : 32'd0;

    // Packet outputs; prediction is forced quiet while reset is held.
    assign bus.fetch_pc_0  = r_pc_p0;
    assign bus.fetch_pc_1  = w_pc1;
    assign bus.pc_out      = r_pc_p0;
    assign bus.slot1_valid = w_slot1_valid;
    assign bus.pc_valid    = reset & ~bus.redirect;
    assign bus.pred_taken  = reset ? w_taken : 2'b00;
    assign bus.pred_target = reset ? w_pred_target : 32'd0;

    // ---- stage p0: fetch PC register ----
    always_ff @(posedge clk) begin
        if (!reset)
            r_pc_p0 <= RESET_PC;
        else if (bus.redirect)
            r_pc_p0 <= bus.redirect_pc;
        else if (bus.if_ready)
            r_pc_p0 <= w_any_taken ? w_pred_target : w_seq_pc;
    end

endmodule
